// File: rtl/isa_pkg.sv
// Thumb-subset ISA constants and helpers shared by fetch and decode.
// Condition codes, branch opcodes, NOOP encoding, offset sign-extension.
package isa_pkg;

  localparam logic [4:0] OP_B     = 5'b11100;
  localparam logic [3:0] OP_BCOND = 4'b1101;

  localparam logic [3:0] COND_EQ  = 4'h0;
  localparam logic [3:0] COND_NE  = 4'h1;
  localparam logic [3:0] COND_CS  = 4'h2;
  localparam logic [3:0] COND_CC  = 4'h3;
  localparam logic [3:0] COND_MI  = 4'h4;
  localparam logic [3:0] COND_PL  = 4'h5;
  localparam logic [3:0] COND_VS  = 4'h6;
  localparam logic [3:0] COND_VC  = 4'h7;
  localparam logic [3:0] COND_HI  = 4'h8;
  localparam logic [3:0] COND_LS  = 4'h9;
  localparam logic [3:0] COND_GE  = 4'hA;
  localparam logic [3:0] COND_LT  = 4'hB;
  localparam logic [3:0] COND_GT  = 4'hC;
  localparam logic [3:0] COND_LE  = 4'hD;
  localparam logic [3:0] COND_AL  = 4'hE;
  localparam logic [3:0] COND_SVC = 4'hF;

  localparam logic [15:0] NOOP_ENC = 16'hBF00;

  function automatic logic [31:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sext11(input logic [10:0] v);
    return {{21{v[10]}}, v};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 4-bit condition code against {N,Z,C,V}.
// AL passes; SVC never passes.
module branch_cond_eval
  import isa_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[3];
  assign z = nzcv[2];
  assign c = nzcv[1];
  assign v = nzcv[0];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ:  pass = z;
      COND_NE:  pass = !z;
      COND_CS:  pass = c;
      COND_CC:  pass = !c;
      COND_MI:  pass = n;
      COND_PL:  pass = !n;
      COND_VS:  pass = v;
      COND_VC:  pass = !v;
      COND_HI:  pass = c && !z;
      COND_LS:  pass = !c || z;
      COND_GE:  pass = (n == v);
      COND_LT:  pass = (n != v);
      COND_GT:  pass = !z && (n == v);
      COND_LE:  pass = z || (n != v);
      COND_AL:  pass = 1'b1;
      COND_SVC: pass = 1'b0;
      default:  pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, IF/ID register, branch resolve with one delay slot.
// FETCH_PERF_CNT_EN adds fetch/taken-branch performance counters.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [15:0]       NOOP_INSTR = NOOP_ENC
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] address,
  input  logic [15:0]       instruction,
  input  logic              stall,
  input  logic [3:0]        flags_nzcv,
  output logic [15:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_taken_cnt,
`endif
  output logic              branch_taken
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic              id_valid_q, id_valid_d;

  logic              is_b, is_bc, cond_pass, is_taken;
  logic [ADDR_W-1:0] off, target, next_pc;

  branch_cond_eval u_cond (
    .cond (id_instr_q[11:8]),
    .nzcv (flags_nzcv),
    .pass (cond_pass)
  );

  assign is_b  = (id_instr_q[15:11] == OP_B);
  assign is_bc = (id_instr_q[15:12] == OP_BCOND)
              && (id_instr_q[11:8] != COND_AL)
              && (id_instr_q[11:8] != COND_SVC);

  always_comb begin
    is_taken = 1'b0;
    off      = '0;
    unique case (1'b1)
      is_b: begin
        is_taken = 1'b1;
        off      = ADDR_W'(sext11(id_instr_q[10:0]));
      end
      is_bc: begin
        is_taken = cond_pass;
        off      = ADDR_W'(sext8(id_instr_q[7:0]));
      end
      default: ;
    endcase
  end

  // A stalled cycle never redirects; the branch re-evaluates on release.
  assign branch_taken = id_valid_q && !stall && is_taken;
  assign target  = id_pc_q + ADDR_W'(1) + off;
  assign next_pc = branch_taken ? target : pc_q + ADDR_W'(1);

  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (!stall) begin
      pc_d       = next_pc;
      id_instr_d = instruction;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOOP_INSTR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign address  = pc_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (!stall) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (branch_taken) taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Instruction memory is a 256-entry table indexed by address[7:0].
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [15:0] instruction;
  logic        stall;
  logic [3:0]  flags_nzcv;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        branch_taken;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_taken_cnt;
`endif

  logic [15:0] mem [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign instruction = mem[address[7:0]];

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .instruction  (instruction),
    .stall        (stall),
    .flags_nzcv   (flags_nzcv),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_taken_cnt (perf_taken_cnt),
`endif
    .branch_taken (branch_taken)
  );

  task automatic fill_noop();
    for (int i = 0; i < 256; i++) mem[i] = 16'hBF00;
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    flags_nzcv = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fill_noop();
    do_reset();
    n_cmp++; if (address !== 16'd0) begin n_bad++; $display("FAIL rst_addr got %h exp %h", address, 16'd0); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instr !== 16'hBF00) begin n_bad++; $display("FAIL rst_instr got %h exp bf00", id_instr); end
    n_cmp++; if (id_pc !== 16'd0) begin n_bad++; $display("FAIL rst_idpc got %h exp 0", id_pc); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL rst_bt got %b exp 0", branch_taken); end
  endtask

  task automatic test_free_run();
    fill_noop();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      adv(1);
      n_cmp++; if (address !== 16'(i)) begin n_bad++; $display("FAIL fr_addr%0d got %h exp %h", i, address, 16'(i)); end
      n_cmp++; if (id_pc !== 16'(i - 1)) begin n_bad++; $display("FAIL fr_idpc%0d got %h exp %h", i, id_pc, 16'(i - 1)); end
      n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL fr_valid%0d got %b exp 1", i, id_valid); end
    end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (perf_fetch_cnt !== 32'd4) begin n_bad++; $display("FAIL fr_pfetch got %0d exp 4", perf_fetch_cnt); end
    n_cmp++; if (perf_taken_cnt !== 32'd0) begin n_bad++; $display("FAIL fr_ptaken got %0d exp 0", perf_taken_cnt); end
`endif
  endtask

  task automatic test_uncond();
    fill_noop();
    mem[10] = 16'hE7F9;
    do_reset();
    adv(11);
    n_cmp++; if (id_instr !== 16'hE7F9) begin n_bad++; $display("FAIL b_instr got %h exp e7f9", id_instr); end
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL b_taken got %b exp 1", branch_taken); end
    n_cmp++; if (address !== 16'd11) begin n_bad++; $display("FAIL b_slot_addr got %h exp 000b", address); end
    adv(1);
    n_cmp++; if (id_pc !== 16'd11) begin n_bad++; $display("FAIL b_slot_idpc got %h exp 000b", id_pc); end
    n_cmp++; if (address !== 16'd4) begin n_bad++; $display("FAIL b_target got %h exp 0004", address); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL b_slot_bt got %b exp 0", branch_taken); end
    adv(1);
    n_cmp++; if (id_pc !== 16'd4) begin n_bad++; $display("FAIL b_tgt_idpc got %h exp 0004", id_pc); end
    n_cmp++; if (address !== 16'd5) begin n_bad++; $display("FAIL b_after got %h exp 0005", address); end
  endtask

  task automatic test_cond_eq();
    fill_noop();
    mem[5] = 16'hD012;
    do_reset();
    flags_nzcv = 4'b0100;
    adv(6);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL eq_z1_bt got %b exp 1", branch_taken); end
    adv(1);
    n_cmp++; if (id_pc !== 16'd6) begin n_bad++; $display("FAIL eq_z1_slot got %h exp 0006", id_pc); end
    n_cmp++; if (address !== 16'd24) begin n_bad++; $display("FAIL eq_z1_tgt got %h exp 0018", address); end
    do_reset();
    flags_nzcv = 4'b0000;
    adv(6);
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL eq_z0_bt got %b exp 0", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'd7) begin n_bad++; $display("FAIL eq_z0_a7 got %h exp 0007", address); end
    adv(1);
    n_cmp++; if (address !== 16'd8) begin n_bad++; $display("FAIL eq_z0_a8 got %h exp 0008", address); end
  endtask

  task automatic test_cond_lt();
    fill_noop();
    mem[3] = 16'hDB05;
    do_reset();
    flags_nzcv = 4'b1000;
    adv(4);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL lt_nv10_bt got %b exp 1", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'd9) begin n_bad++; $display("FAIL lt_tgt got %h exp 0009", address); end
    do_reset();
    flags_nzcv = 4'b1001;
    adv(4);
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL lt_nv11_bt got %b exp 0", branch_taken); end
    mem[3] = 16'hDF05;
    do_reset();
    flags_nzcv = 4'b1000;
    adv(4);
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL svc_bt got %b exp 0", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'd5) begin n_bad++; $display("FAIL svc_addr got %h exp 0005", address); end
    mem[3] = 16'hDE05;
    do_reset();
    adv(4);
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL al_bt got %b exp 0", branch_taken); end
  endtask

  task automatic test_stall();
    fill_noop();
    mem[5] = 16'hD012;
    do_reset();
    adv(6);
    stall = 1'b1;
    flags_nzcv = 4'b0100;
    #1;
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL st_bt got %b exp 0", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'd6) begin n_bad++; $display("FAIL st_addr got %h exp 0006", address); end
    n_cmp++; if (id_pc !== 16'd5) begin n_bad++; $display("FAIL st_idpc got %h exp 0005", id_pc); end
    n_cmp++; if (id_instr !== 16'hD012) begin n_bad++; $display("FAIL st_instr got %h exp d012", id_instr); end
    flags_nzcv = 4'b0000;
    adv(2);
    n_cmp++; if (address !== 16'd6) begin n_bad++; $display("FAIL st_addr3 got %h exp 0006", address); end
    stall = 1'b0;
    flags_nzcv = 4'b0100;
    #1;
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL st_rel_bt got %b exp 1", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'd24) begin n_bad++; $display("FAIL st_rel_tgt got %h exp 0018", address); end
    n_cmp++; if (id_pc !== 16'd6) begin n_bad++; $display("FAIL st_rel_idpc got %h exp 0006", id_pc); end
  endtask

  task automatic test_reset_mid();
    fill_noop();
    mem[10] = 16'hE7F9;
    do_reset();
    adv(11);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL rm_pre_bt got %b exp 1", branch_taken); end
    do_reset();
    n_cmp++; if (address !== 16'd0) begin n_bad++; $display("FAIL rm_addr got %h exp 0000", address); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b exp 0", id_valid); end
    n_cmp++; if (id_instr !== 16'hBF00) begin n_bad++; $display("FAIL rm_instr got %h exp bf00", id_instr); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL rm_bt got %b exp 0", branch_taken); end
  endtask

  task automatic test_wrap();
    fill_noop();
    mem[0] = 16'hE7FE;
    do_reset();
    adv(1);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL wr_bt got %b exp 1", branch_taken); end
    adv(1);
    n_cmp++; if (address !== 16'hFFFF) begin n_bad++; $display("FAIL wr_tgt got %h exp ffff", address); end
    adv(1);
    n_cmp++; if (address !== 16'h0000) begin n_bad++; $display("FAIL wr_wrap got %h exp 0000", address); end
    n_cmp++; if (id_pc !== 16'hFFFF) begin n_bad++; $display("FAIL wr_idpc got %h exp ffff", id_pc); end
  endtask

  task automatic test_back_to_back();
    fill_noop();
    mem[10] = 16'hE7F9;
    mem[11] = 16'hE005;
    do_reset();
    adv(11);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL bb_first got %b exp 1", branch_taken); end
    adv(1);
    n_cmp++; if (branch_taken !== 1'b1) begin n_bad++; $display("FAIL bb_second got %b exp 1", branch_taken); end
    n_cmp++; if (address !== 16'd4) begin n_bad++; $display("FAIL bb_addr4 got %h exp 0004", address); end
    adv(1);
    n_cmp++; if (id_pc !== 16'd4) begin n_bad++; $display("FAIL bb_idpc4 got %h exp 0004", id_pc); end
    n_cmp++; if (address !== 16'd17) begin n_bad++; $display("FAIL bb_addr17 got %h exp 0011", address); end
    adv(1);
    n_cmp++; if (address !== 16'd18) begin n_bad++; $display("FAIL bb_addr18 got %h exp 0012", address); end
`ifdef FETCH_PERF_CNT_EN
    n_cmp++; if (perf_taken_cnt !== 32'd2) begin n_bad++; $display("FAIL bb_ptaken got %0d exp 2", perf_taken_cnt); end
    n_cmp++; if (perf_fetch_cnt !== 32'd14) begin n_bad++; $display("FAIL bb_pfetch got %0d exp 14", perf_fetch_cnt); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flags_nzcv = 4'h0;
    fill_noop();
    test_reset();
    test_free_run();
    test_uncond();
    test_cond_eq();
    test_cond_lt();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
